// File: rtl/ifu_pkg.sv
// Shared IF-stage constants, FSM encoding and prefetch entry layout.
// Consumed by instr_fetch_unit (IFU_RESET_VECTOR_EN selects the vectored boot path).
package ifu_pkg;

    localparam int IFU_ADDR_W = 8;
    localparam int IFU_DATA_W = 8;

    typedef logic [IFU_ADDR_W-1:0] ifu_addr_t;
    typedef logic [IFU_DATA_W-1:0] ifu_data_t;

    localparam ifu_addr_t IFU_RESET_PC = 8'h00;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_VEC   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    typedef struct packed {
        ifu_data_t instr;
        ifu_addr_t pc;
    } ifu_entry_t;

    function automatic ifu_addr_t pc_inc(input ifu_addr_t pc);
        return pc + ifu_addr_t'(1);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// IF-stage bundle: instruction memory req/ack side and IF->ID byte stream.
// master = fetch unit, slave = memory plus decode/control side.
interface ifu_if;
    import ifu_pkg::*;

    logic      imem_req;
    ifu_addr_t imem_addr;
    logic      imem_ack;
    ifu_data_t imem_rdata;
    ifu_data_t if_instruction;
    ifu_addr_t if_pc;
    logic      if_valid;
    logic      if_ready;
    logic      stall;
    logic      branch_taken;
    ifu_addr_t branch_target;
    logic      busy;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_instruction, if_pc, if_valid,
        input  if_ready, stall,
        input  branch_taken, branch_target,
        output busy
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_instruction, if_pc, if_valid,
        output if_ready, stall,
        output branch_taken, branch_target,
        input  busy
    );

endinterface

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {byte, address} entries with synchronous clear.
// Clear wins over push; head is read combinationally.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  ifu_entry_t    din_i,
    output ifu_entry_t    dout_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    ifu_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i & (cnt_q != '0);
    assign do_push = push_i & ((cnt_q != FULL_C) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: fetch PC, single-outstanding imem req/ack, prefetch FIFO, branch redirect.
// Define IFU_RESET_VECTOR_EN to boot from the PC stored at address 0.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int        DEPTH    = 4,
    parameter ifu_addr_t RESET_PC = IFU_RESET_PC
) (
    input logic   clk,
    input logic   rst_n,
    ifu_if.master bus
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef IFU_RESET_VECTOR_EN
    localparam logic [1:0]    S_BOOT  = S_VEC;
`else
    localparam logic [1:0]    S_BOOT  = S_RUN;
`endif

    logic [1:0]    state_q, state_d;
    ifu_addr_t     pc_q, pc_d;
    ifu_addr_t     addr_q, addr_d;
    logic          out_q, out_d;
    logic          stale_q, stale_d;

    logic          issue;
    ifu_addr_t     req_addr;
    logic          push;
    logic          pop;
    logic          clr;
    logic          valid;
    logic          brk;
    logic [CW-1:0] count;
    ifu_entry_t    head;
    ifu_entry_t    din;

    assign valid = (count != '0);
    assign brk   = (state_q == S_RUN) & bus.branch_taken;
    assign pop   = valid & bus.if_ready & ~bus.stall & ~brk;
    assign din   = '{instr: bus.imem_rdata, pc: req_addr};

    // A request is combinational in its first cycle; out_q carries it afterwards.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        out_d    = out_q;
        stale_d  = stale_q;
        issue    = 1'b0;
        req_addr = addr_q;
        push     = 1'b0;
        clr      = 1'b0;
        unique case (state_q)
            S_RESET: state_d = S_BOOT;
`ifdef IFU_RESET_VECTOR_EN
            S_VEC: begin
                issue = ~out_q;
                if (!out_q) req_addr = '0;
                if (bus.imem_ack) begin
                    out_d   = 1'b0;
                    pc_d    = bus.imem_rdata;
                    state_d = S_RUN;
                end else begin
                    out_d = 1'b1;
                end
            end
`endif
            S_RUN: begin
                issue = ~out_q & ~bus.branch_taken & (count < DEPTH_C);
                if (issue) req_addr = pc_q;
                if (bus.branch_taken) begin
                    clr     = 1'b1;
                    pc_d    = bus.branch_target;
                    out_d   = out_q & ~bus.imem_ack;
                    stale_d = out_q & ~bus.imem_ack;
                end else if ((out_q | issue) && bus.imem_ack) begin
                    out_d   = 1'b0;
                    stale_d = 1'b0;
                    push    = ~stale_q;
                    if (!stale_q) pc_d = pc_inc(pc_q);
                end else if (issue) begin
                    out_d = 1'b1;
                end
            end
            default: state_d = S_RESET;
        endcase
        if (issue) addr_d = req_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            out_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            stale_q <= stale_d;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .dout_o  (head),
        .count_o (count)
    );

    assign bus.imem_req       = out_q | issue;
    assign bus.imem_addr      = req_addr;
    assign bus.if_valid       = valid;
    assign bus.if_instruction = valid ? head.instr : '0;
    assign bus.if_pc          = valid ? head.pc : '0;
    assign bus.busy           = out_q | valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-programmable memory responder and a
// scoreboard of expected {byte, pc} pairs checked on every accepted head byte.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFU_RESET_VECTOR_EN
    localparam logic [7:0] START = 8'h20;
    localparam logic [7:0] NEXT1 = 8'h20;
    localparam int         PRE   = 1;
`else
    localparam logic [7:0] START = 8'h00;
    localparam logic [7:0] NEXT1 = 8'h01;
    localparam int         PRE   = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_if bus ();

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          cnt = 0;
    int          acks = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  addrs [$];
    logic [15:0] e;
    logic [7:0]  hp, hi;
    int          n, n0;

    function automatic logic [7:0] memf(input logic [7:0] a);
        logic [7:0] r;
        r = {a[3:0], a[7:4]} ^ 8'h3C;
`ifdef IFU_RESET_VECTOR_EN
        if (a == 8'h00) r = 8'h20;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] p);
        exp_q.push_back({memf(p), p});
    endtask

    // Memory: ack after lat cycles of req; each ack ends the request.
    always @(negedge clk) begin
        if (bus.imem_ack) cnt = 0;
        bus.imem_ack = 1'b0;
        if (rst_n && bus.imem_req) begin
            cnt++;
            if (cnt >= lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = memf(bus.imem_addr);
                addrs.push_back(bus.imem_addr);
                acks++;
            end
        end else begin
            cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.if_valid && bus.if_ready && !bus.stall && !bus.branch_taken) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %0h byte %0h expected none",
                         bus.if_pc, bus.if_instruction);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", bus.if_pc, e[7:0]);
                chk("pop_byte", bus.if_instruction, e[15:8]);
            end
        end
    end

    task automatic do_reset(input int l, input logic rdy);
        rst_n = 1'b0;
        bus.if_ready = rdy;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        lat = l;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_instr", bus.if_instruction, 0);
        chk("rst_pc", bus.if_pc, 0);
        chk("rst_busy", bus.busy, 0);
        exp_q.delete();
        addrs.delete();
        acks = 0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        bus.if_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic branch_to(input logic [7:0] t);
        bus.branch_taken = 1'b1;
        bus.branch_target = t;
        @(posedge clk);
        #1;
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;

        // Sequential fetch with 1-cycle ack
        do_reset(1, 1'b1);
        for (int i = 0; i < 8; i++) push_exp(START + 8'(i));
        repeat (2 + PRE) @(posedge clk);
        #1;
        chk("t1_first_valid", bus.if_valid, 1);
        chk("t1_first_pc", bus.if_pc, START);
        chk("t1_first_byte", bus.if_instruction, memf(START));
        drain(60);
        chk("t1_addr0", addrs[0], 8'h00);
        chk("t1_addr1", addrs[1], NEXT1);

        // Backpressure: prefetch stops at DEPTH
        do_reset(1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_acks", acks, DEPTH + PRE);
        chk("t2_req_idle", bus.imem_req, 0);
        chk("t2_busy", bus.busy, 1);
        for (int i = 0; i < 6; i++) push_exp(START + 8'(i));
        bus.if_ready = 1'b1;
        drain(60);

        // Branch with a request outstanding, ack latency 3
        do_reset(3, 1'b1);
        push_exp(START);
        push_exp(START + 8'd1);
        drain(60);
        n = 0;
        while (!(bus.imem_req && cnt == 1) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_outstanding", bus.imem_req, 1);
        n0 = addrs.size();
        branch_to(8'h40);
        chk("t3_flush", bus.if_valid, 0);
        for (int i = 0; i < 4; i++) push_exp(8'h40 + 8'(i));
        bus.if_ready = 1'b1;
        drain(80);
        chk("t3_stale_addr", addrs[n0], START + 8'd2);
        chk("t3_target_addr", addrs[n0+1], 8'h40);

        // Reset while a request is pending
        lat = 5;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("t3_midrst_req", bus.imem_req, 0);
        chk("t3_midrst_busy", bus.busy, 0);
        chk("t3_midrst_valid", bus.if_valid, 0);

        // Stall holds the head while the FIFO fills
        do_reset(1, 1'b1);
        for (int i = 0; i < 12; i++) push_exp(START + 8'(i));
        n = 0;
        while (!bus.if_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_valid", bus.if_valid, 1);
        bus.stall = 1'b1;
        hp = bus.if_pc;
        hi = bus.if_instruction;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_pc", bus.if_pc, hp);
            chk("t4_hold_byte", bus.if_instruction, hi);
        end
        @(posedge clk);
        #1;
        chk("t4_full_req", bus.imem_req, 0);
        chk("t4_busy", bus.busy, 1);
        bus.stall = 1'b0;
        drain(60);

        // PC wrap after redirect to FE
        do_reset(1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        n0 = addrs.size();
        branch_to(8'hFE);
        push_exp(8'hFE);
        push_exp(8'hFF);
        push_exp(8'h00);
        push_exp(8'h01);
        bus.if_ready = 1'b1;
        drain(60);
        chk("t5_addr_fe", addrs[n0], 8'hFE);
        chk("t5_addr_ff", addrs[n0+1], 8'hFF);
        chk("t5_addr_00", addrs[n0+2], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
